pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the KGP_RISC fetch stage. It replaces the fixed 8-bit +1 incrementor with a registered PC that can advance sequentially, take relative branches, take absolute jumps, stall, and handle call/return through an internal return-address stack (RAS). The instruction memory is addressed by `pc`; `pc_next` feeds any look-ahead logic.

---
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Registered program counter for the KGP_RISC fetch stage.
//               Supports sequential advance, relative branch, absolute jump,
//               stall, and call/return through a circular return-address
//               stack that overwrites its oldest entry when full.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam int unsigned     AW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned     CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0] STEP_C  = PC_W'(STEP);
  localparam logic [PC_W-1:0] RESET_C = PC_W'(RESET_PC);
  localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   top_q, top_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push, pop;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] ras_mem [RAS_DEPTH];

  // The ret path wins over call; a simultaneous call is dropped and flagged.
  always_comb begin
    seq_pc = pc_q + STEP_C;
    pc_d   = pc_q;
    push   = 1'b0;
    pop    = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (cnt_q != '0) begin
          pc_d = ras_mem[top_q];
          pop  = 1'b1;
        end else begin
          pc_d  = seq_pc;
          unf_d = 1'b1;
        end
        if (call) begin
          unf_d = 1'b1;
        end
      end else if (call) begin
        pc_d  = jmp_target;
        push  = 1'b1;
        ovf_d = (cnt_q == DEPTH_C);
      end else if (jmp) begin
        pc_d = jmp_target;
      end else if (br_taken) begin
        pc_d = seq_pc + br_offset;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  // Stack pointer and occupancy; a full push advances the pointer onto the
  // oldest slot so it gets overwritten while the count saturates.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      top_d = top_q + PTR_ONE;
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (pop) begin
      top_d = top_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // PC, stack bookkeeping and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_C;
      cnt_q <= '0;
      top_q <= '1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[top_q + PTR_ONE] <= seq_pc;
    end
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == DEPTH_C);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed, table-driven self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       stall, br_taken, jmp, call, ret;
  logic [7:0] br_offset, jmp_target;
  logic [7:0] pc, pc_next;
  logic       ras_empty, ras_full, ras_ovf, ras_unf;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       st;
    logic       br;
    logic [7:0] off;
    logic       jp;
    logic       cl;
    logic       rt;
    logic [7:0] tgt;
    logic [7:0] e_pc;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  pc_sequencer #(
    .PC_W(8), .STEP(1), .RESET_PC(0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jmp(jmp), .call(call), .ret(ret),
    .jmp_target(jmp_target), .pc(pc), .pc_next(pc_next),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic br, input logic [7:0] off,
                     input logic jp, input logic cl, input logic rt,
                     input logic [7:0] tgt, input logic [7:0] e_pc,
                     input logic e_empty, input logic e_full,
                     input logic e_ovf, input logic e_unf);
    vec_t v;
    v.st = st; v.br = br; v.off = off; v.jp = jp; v.cl = cl; v.rt = rt;
    v.tgt = tgt; v.e_pc = e_pc; v.e_empty = e_empty; v.e_full = e_full;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  // Drive one vector on the falling edge, check pc_next, then the state after the rise.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    stall = v.st; br_taken = v.br; br_offset = v.off; jmp = v.jp;
    call = v.cl; ret = v.rt; jmp_target = v.tgt;
    #1;
    check($sformatf("v%0d pc_next", idx), pc_next, v.e_pc);
    @(posedge clk);
    #1;
    check($sformatf("v%0d pc", idx), pc, v.e_pc);
    check($sformatf("v%0d empty", idx), {7'd0, ras_empty}, {7'd0, v.e_empty});
    check($sformatf("v%0d full", idx), {7'd0, ras_full}, {7'd0, v.e_full});
    check($sformatf("v%0d ovf", idx), {7'd0, ras_ovf}, {7'd0, v.e_ovf});
    check($sformatf("v%0d unf", idx), {7'd0, ras_unf}, {7'd0, v.e_unf});
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; br_offset = 8'h00; jmp = 0; call = 0; ret = 0;
    jmp_target = 8'h00;
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    rst_n = 1'b0;

    //           st br off   jp cl rt tgt    pc     emp fu ov un
    add(0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 1, 0, 0, 0); // jump to 0x10
    add(0, 1, 8'hFC, 0, 0, 0, 8'h00, 8'h0D, 1, 0, 0, 0); // branch -4
    add(0, 1, 8'h05, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 0); // jmp beats branch
    add(0, 0, 8'h00, 1, 0, 0, 8'h20, 8'h20, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0, 0); // call, push 0x21
    add(0, 0, 8'h00, 0, 1, 0, 8'h60, 8'h60, 0, 0, 0, 0); // call, push 0x41
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h41, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h21, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h22, 1, 0, 0, 1); // ret on empty
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h23, 1, 0, 0, 0); // pulse drops
    add(0, 0, 8'h00, 1, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 8'h02, 8'h02, 0, 0, 0, 0); // push 0x02
    add(0, 0, 8'h00, 0, 1, 0, 8'h03, 8'h03, 0, 0, 0, 0); // push 0x03
    add(0, 0, 8'h00, 0, 1, 0, 8'h04, 8'h04, 0, 0, 0, 0); // push 0x04
    add(0, 0, 8'h00, 0, 1, 0, 8'h05, 8'h05, 0, 1, 0, 0); // push 0x05, full
    add(0, 0, 8'h00, 0, 1, 0, 8'h10, 8'h10, 0, 1, 1, 0); // push 0x06 over 0x02
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h06, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h05, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h04, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h03, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h04, 1, 0, 0, 1); // underflow
    add(0, 0, 8'h00, 0, 1, 0, 8'h08, 8'h08, 0, 0, 0, 0); // push 0x05
    add(1, 0, 8'h00, 0, 1, 0, 8'h30, 8'h08, 0, 0, 0, 0); // stalled call
    add(1, 0, 8'h00, 0, 0, 1, 8'h00, 8'h08, 0, 0, 0, 0); // stalled ret
    add(1, 1, 8'h10, 1, 0, 0, 8'h70, 8'h08, 0, 0, 0, 0); // stalled jmp/br
    add(0, 0, 8'h00, 0, 1, 1, 8'h50, 8'h05, 1, 0, 0, 1); // call+ret: pop only
    add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h06, 1, 0, 0, 1); // proves no push
    add(0, 1, 8'h7F, 0, 0, 0, 8'h00, 8'h86, 1, 0, 0, 0); // 0x07 + 0x7F

    // Reset state while held low.
    repeat (2) @(posedge clk);
    #1;
    check("rst pc", pc, 8'h00);
    check("rst empty", {7'd0, ras_empty}, 8'd1);
    check("rst full", {7'd0, ras_full}, 8'd0);
    check("rst ovf", {7'd0, ras_ovf}, 8'd0);
    check("rst unf", {7'd0, ras_unf}, 8'd0);

    // Release and free-run through a full wrap.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("inc %0d pc", i), pc, 8'(i));
      check($sformatf("inc %0d pulses", i), {6'd0, ras_ovf, ras_unf}, 8'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply(v, i);
    end

    // Build two RAS entries, then reset asynchronously between edges.
    @(negedge clk);
    idle_inputs();
    call = 1; jmp_target = 8'h40;
    @(negedge clk);
    jmp_target = 8'h60;
    @(negedge clk);
    idle_inputs();
    #1;
    check("pre-arst pc", pc, 8'h60);
    check("pre-arst empty", {7'd0, ras_empty}, 8'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst pc", pc, 8'h00);
    check("arst empty", {7'd0, ras_empty}, 8'd1);
    check("arst full", {7'd0, ras_full}, 8'd0);

    // First edge after release performs a normal selection from reset.
    @(negedge clk);
    rst_n = 1'b1;
    ret = 1;
    #1;
    check("post-arst pc_next", pc_next, 8'h01);
    @(posedge clk);
    #1;
    check("post-arst pc", pc, 8'h01);
    check("post-arst unf", {7'd0, ras_unf}, 8'd1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check("post-arst idle pc", pc, 8'h02);
    check("post-arst unf clr", {7'd0, ras_unf}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
